// File: rtl/fifo_pkg.sv
// Shared defaults and elaboration-time helpers for the parametrised FIFO.
package fifo_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH      = 16;

  // Occupancy must reach DEPTH itself, so one bit wider than the address.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit depth_ok(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit levels_ok(input int unsigned depth, input int unsigned af_level,
                                   input int unsigned ae_level);
    return (af_level >= 1) && (af_level <= depth) && (ae_level <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, registered enabled read.
module fifo_ram #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned Depth     = 16,
  parameter int unsigned AddrWidth = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [AddrWidth-1:0] wr_addr,
  input  logic [DataWidth-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [AddrWidth-1:0] rd_addr,
  output logic [DataWidth-1:0] rd_data
);

  logic [DataWidth-1:0] mem [Depth];
  logic [DataWidth-1:0] rd_data_q;

  // Storage is deliberately not reset; reads are gated by occupancy upstream.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with registered status flags and sticky error reporting.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = DEFAULT_DATA_WIDTH,
  parameter int unsigned BUFFER_DEPTH       = DEFAULT_DEPTH,
  parameter int unsigned ALMOST_FULL_LEVEL  = 12,
  parameter int unsigned ALMOST_EMPTY_LEVEL = 4,
  localparam int unsigned ADDR_WIDTH        = $clog2(BUFFER_DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_Enable,
  input  logic [DATA_WIDTH-1:0] buffer_Input,
  input  logic                  read_Enable,
  input  logic                  clear_Errors,
  output logic [DATA_WIDTH-1:0] buffer_Output,
  output logic                  read_Valid,
  output logic                  sig_Full,
  output logic                  sig_Empty,
  output logic                  sig_Almost_Full,
  output logic                  sig_Almost_Empty,
  output logic [ADDR_WIDTH:0]   fill_Count,
  output logic                  sig_Overflow,
  output logic                  sig_Underflow
);

  localparam int unsigned CntWidth = count_width(BUFFER_DEPTH);

  localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(BUFFER_DEPTH);
  localparam logic [CntWidth-1:0] AfCnt    = CntWidth'(ALMOST_FULL_LEVEL);
  localparam logic [CntWidth-1:0] AeCnt    = CntWidth'(ALMOST_EMPTY_LEVEL);

  if (!depth_ok(BUFFER_DEPTH)) begin : g_bad_depth
    $error("param_fifo: BUFFER_DEPTH must be a power of two and at least 2");
  end
  if (!levels_ok(BUFFER_DEPTH, ALMOST_FULL_LEVEL, ALMOST_EMPTY_LEVEL)) begin : g_bad_levels
    $error("param_fifo: almost-full/almost-empty level out of range");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0]   count_q, count_d;
  logic                  full_q, empty_q, afull_q, aempty_q;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  valid_q;
  logic                  rd_ok, wr_ok;

  // A read on a full FIFO frees its slot in the same cycle.
  assign rd_ok = read_Enable && !empty_q;
  assign wr_ok = write_Enable && (!full_q || rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CntWidth'(1);
      2'b01:   count_d = count_q - CntWidth'(1);
      default: count_d = count_q;
    endcase
  end

  // Set wins over clear for the sticky flags.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (clear_Errors) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (write_Enable && !wr_ok) ovf_d = 1'b1;
    if (read_Enable && empty_q) unf_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DepthCnt);
      empty_q  <= (count_d == '0);
      afull_q  <= (count_d >= AfCnt);
      aempty_q <= (count_d <= AeCnt);
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      valid_q  <= rd_ok;
    end
  end

  fifo_ram #(
    .DataWidth (DATA_WIDTH),
    .Depth     (BUFFER_DEPTH),
    .AddrWidth (ADDR_WIDTH)
  ) u_ram (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr_q),
    .wr_data (buffer_Input),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr_q),
    .rd_data (buffer_Output)
  );

  assign read_Valid       = valid_q;
  assign sig_Full         = full_q;
  assign sig_Empty        = empty_q;
  assign sig_Almost_Full  = afull_q;
  assign sig_Almost_Empty = aempty_q;
  assign fill_Count       = count_q;
  assign sig_Overflow     = ovf_q;
  assign sig_Underflow    = unf_q;

endmodule

// File: tb/tb_param_fifo.sv
// Directed and randomized checks of param_fifo against a queue-based reference model.
module tb_param_fifo;

  localparam int Depth = 16;
  localparam int AfLvl = 12;
  localparam int AeLvl = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       write_Enable = 1'b0;
  logic [7:0] buffer_Input = 8'h00;
  logic       read_Enable = 1'b0;
  logic       clear_Errors = 1'b0;
  logic [7:0] buffer_Output;
  logic       read_Valid, sig_Full, sig_Empty, sig_Almost_Full, sig_Almost_Empty;
  logic [4:0] fill_Count;
  logic       sig_Overflow, sig_Underflow;

  param_fifo #(
    .DATA_WIDTH         (8),
    .BUFFER_DEPTH       (Depth),
    .ALMOST_FULL_LEVEL  (AfLvl),
    .ALMOST_EMPTY_LEVEL (AeLvl)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .write_Enable     (write_Enable),
    .buffer_Input     (buffer_Input),
    .read_Enable      (read_Enable),
    .clear_Errors     (clear_Errors),
    .buffer_Output    (buffer_Output),
    .read_Valid       (read_Valid),
    .sig_Full         (sig_Full),
    .sig_Empty        (sig_Empty),
    .sig_Almost_Full  (sig_Almost_Full),
    .sig_Almost_Empty (sig_Almost_Empty),
    .fill_Count       (fill_Count),
    .sig_Overflow     (sig_Overflow),
    .sig_Underflow    (sig_Underflow)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: an ordered queue of stored words plus observable registers.
  logic [7:0] m_q[$];
  logic [7:0] m_out;
  logic       m_valid, m_ovf, m_unf;
  int         n_reads_55;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_out   = 8'h00;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int cnt;
    cnt = m_q.size();
    chk({tag, ".count"}, 32'(fill_Count), 32'(cnt));
    chk({tag, ".full"}, 32'(sig_Full), 32'(cnt == Depth));
    chk({tag, ".empty"}, 32'(sig_Empty), 32'(cnt == 0));
    chk({tag, ".afull"}, 32'(sig_Almost_Full), 32'(cnt >= AfLvl));
    chk({tag, ".aempty"}, 32'(sig_Almost_Empty), 32'(cnt <= AeLvl));
    chk({tag, ".valid"}, 32'(read_Valid), 32'(m_valid));
    chk({tag, ".data"}, 32'(buffer_Output), 32'(m_out));
    chk({tag, ".ovf"}, 32'(sig_Overflow), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(sig_Underflow), 32'(m_unf));
  endtask

  // One clock of traffic: drive, clock, update the model from its pre-edge state, compare.
  task automatic step(input string tag, input logic we, input logic [7:0] wd, input logic re,
                      input logic ce);
    bit rd_ok, wr_ok, was_empty;
    write_Enable = we;
    buffer_Input = wd;
    read_Enable  = re;
    clear_Errors = ce;
    @(posedge clock);
    #1;
    was_empty = (m_q.size() == 0);
    rd_ok = re && !was_empty;
    wr_ok = we && ((m_q.size() < Depth) || rd_ok);
    m_valid = rd_ok;
    if (rd_ok) m_out = m_q.pop_front();
    if (wr_ok) m_q.push_back(wd);
    if (ce) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (we && !wr_ok) m_ovf = 1'b1;
    if (re && was_empty) m_unf = 1'b1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    n_reads_55 = 0;
    repeat (2) @(posedge clock);
    #1;
    check_all("reset");
    @(negedge clock);
    reset = 1'b1;

    for (int i = 1; i <= 16; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill.full_reached", 32'(sig_Full), 32'd1);
    step("overflow", 1'b1, 8'hAA, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain.order", 32'(buffer_Output), 32'(i));
    end

    for (int i = 0; i < 16; i++) step("refill", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      step("full_rw", 1'b1, 8'h55, 1'b1, 1'b0);
      if (buffer_Output == 8'h55) n_reads_55++;
    end
    chk("full_rw.n55", 32'(n_reads_55), 32'd4);
    for (int i = 0; i < 16; i++) step("drain55", 1'b0, 8'h00, 1'b1, 1'b0);

    step("clear_all", 1'b0, 8'h00, 1'b0, 1'b1);
    step("empty_rw", 1'b1, 8'h33, 1'b1, 1'b0);
    chk("empty_rw.unf", 32'(sig_Underflow), 32'd1);
    step("read33", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("read33.data", 32'(buffer_Output), 32'h33);
    step("clear_alone", 1'b0, 8'h00, 1'b0, 1'b1);
    step("clear_vs_unf", 1'b0, 8'h00, 1'b1, 1'b1);
    chk("clear_vs_unf.unf", 32'(sig_Underflow), 32'd1);
    step("clear_again", 1'b0, 8'h00, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      step("wrap", 1'b1, 8'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
    end
    for (int i = 0; i < 300; i++) begin
      step("random", ($urandom_range(0, 1) == 1), 8'($urandom), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 7) == 0));
    end

    // Mid-burst asynchronous reset, taken between clock edges.
    for (int i = 0; i < 6; i++) step("preburst", 1'b1, 8'($urandom), (i == 5), 1'b0);
    write_Enable = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    write_Enable = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step("post_reset", ($urandom_range(0, 1) == 1), 8'($urandom), ($urandom_range(0, 1) == 1),
           1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/param_fifo.md
# param_fifo

Parametrised synchronous FIFO, the next-generation replacement for the fixed 8×8 FIFO memory. It generalises data width and depth and sizes its occupancy counter so the full state is reachable. It adds a single-cycle simultaneous read/write, almost-full/almost-empty thresholds, an occupancy output, a registered read-data valid strobe, and sticky overflow/underflow error flags. It sits between a single-clock producer and consumer in the datapath.

## Interface
- DATA_WIDTH, 8, width of each stored word
- BUFFER_DEPTH, 16, number of entries; power of two, at least 2
- ALMOST_FULL_LEVEL, 12, sig_Almost_Full asserts when count ≥ this value; range 1..BUFFER_DEPTH
- ALMOST_EMPTY_LEVEL, 4, sig_Almost_Empty asserts when count ≤ this value; range 0..BUFFER_DEPTH-1
- ADDR_WIDTH, a derived localparam equal to $clog2(BUFFER_DEPTH); not overridable
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- write_Enable  in  1  write request
- buffer_Input  in  DATA_WIDTH  write data
- read_Enable  in  1  read request
- clear_Errors  in  1  synchronous clear of the sticky error flags
- buffer_Output  out  DATA_WIDTH  registered read data
- read_Valid  out  1  buffer_Output was loaded by the previous edge
- sig_Full  out  1  count == BUFFER_DEPTH
- sig_Empty  out  1  count == 0
- sig_Almost_Full  out  1  count ≥ ALMOST_FULL_LEVEL
- sig_Almost_Empty  out  1  count ≤ ALMOST_EMPTY_LEVEL
- fill_Count  out  ADDR_WIDTH+1  current occupancy, 0..BUFFER_DEPTH
- sig_Overflow  out  1  sticky: a write was dropped
- sig_Underflow  out  1  sticky: a read was refused

## Operation
- Accepted read (rd_ok): read_Enable && !sig_Empty.
- Accepted write (wr_ok): write_Enable && (!sig_Full || rd_ok). When the FIFO is full, a simultaneous read frees the slot in the same cycle.
- On wr_ok: mem[wr_ptr] <= buffer_Input, and wr_ptr increments.
- On rd_ok: buffer_Output <= mem[rd_ptr], and rd_ptr increments.
- Pointers are ADDR_WIDTH bits wide and wrap naturally from BUFFER_DEPTH-1 to 0.
- Count update: +1 on wr_ok only, −1 on rd_ok only, unchanged when both or neither occur.
- Count is ADDR_WIDTH+1 bits wide and never leaves the range 0..BUFFER_DEPTH.
- Empty with both requests: the write is accepted, the read is refused, and sig_Underflow sets. There is no read-through: the written word is readable on a later cycle.
- Overflow: write_Enable && sig_Full && !rd_ok. The data is dropped, the pointers and count are unchanged, and sig_Overflow <= 1.
- Underflow: read_Enable && sig_Empty. buffer_Output holds its value, read_Valid stays 0, and sig_Underflow <= 1.
- Error flags stay set until clear_Errors. If clear_Errors and a new error occur in the same cycle, the flag stays set (set wins).
- When there is no rd_ok, buffer_Output holds its last value.
- Reset values:
  - all pointers and fill_Count = 0
  - buffer_Output = 0, read_Valid = 0
  - sig_Empty = 1, sig_Full = 0
  - sig_Almost_Empty = 1, sig_Almost_Full = 0
  - sig_Overflow = 0, sig_Underflow = 0
  - memory contents are not reset
- Reset asserted mid-operation empties the FIFO immediately, independent of the clock. Stale memory contents are never visible after reset, because a read requires count > 0.

## Timing
- All status flags are registered and computed from the next count, so they change on the same edge as fill_Count. There are no combinational paths from inputs to status outputs.
- Read latency is 1 cycle: with rd_ok at edge N, buffer_Output and read_Valid=1 are valid after edge N. read_Valid is high for exactly one cycle per accepted read.
- Write-to-read latency is 1 cycle: a word written at edge N can be read (rd_ok) at edge N+1, and appears on buffer_Output after edge N+1.
- Sustained throughput is one read and one write per cycle at any fill level, including full and (for writes) empty.

## Structure
- Package fifo_pkg holds:
  - default constants DEFAULT_DATA_WIDTH and DEFAULT_DEPTH
  - a function computing the count width
  - parameter legality checks (power-of-two depth, threshold ranges), asserted at elaboration
- One sub-module, fifo_ram: a simple dual-port array with a synchronous write port and a registered read port with read enable. Everything else (pointers, count, flags, errors) lives in param_fifo.

## Test plan
All scenarios use DATA_WIDTH=8 and BUFFER_DEPTH=16, with thresholds 12 and 4.
- Reset, then write 0x01..0x10 over 16 cycles:
  - fill_Count reaches 16 and sig_Full=1
  - sig_Almost_Full first asserts after the 12th write
  - sig_Almost_Empty deasserts after the 5th write
- Full, then write 0xAA with no read: sig_Overflow=1, fill_Count stays 16. Then read 16 words: data is 0x01..0x10 in order, one read_Valid pulse per word, and sig_Empty=1 at the end.
- Full, simultaneous read and write of 0x55 every cycle for 20 cycles:
  - fill_Count stays 16 and sig_Full stays 1
  - no overflow occurs
  - output order is preserved and 0x55 appears from the 17th read onward
- Empty, simultaneous read and write of 0x33:
  - sig_Underflow=1 and read_Valid=0
  - fill_Count=1
  - the next cycle's read returns 0x33 with read_Valid=1
- Error flags: assert clear_Errors alone, and both flags return to 0. Assert clear_Errors together with read_Enable while empty, and sig_Underflow stays 1.
- Wrap and reset: 40 cycles of interleaved traffic wrap the pointers twice with data intact. Then reset asserted mid-burst immediately gives fill_Count=0, sig_Empty=1, and read_Valid=0.
